reg_file_mp: RTL and testbench
==============================

# reg_file_mp

Parametrised multi-port register file for the MIPS pipeline decode stage: NUM_RD registered read ports, one write port, hardwired-zero register 0, a per-register pending scoreboard for load-use interlock, and a post-reset sweep that clears storage. It sits between ID (read addresses, lock requests) and WB (write-back), and replaces the single-read-pair register file.

## Interface
- DATA_W, 32: register width in bits
- DEPTH, 32: number of registers; power of two, at least 2
- AW, log2(DEPTH): register address width
- NUM_RD, 2: number of read ports, 1..4
- clk  in  1  clock; all logic on rising edge
- reset  in  1  synchronous, active-high reset
- iRdEn  in  NUM_RD  per-port read enable
- iRdAddr  in  NUM_RD*AW  packed read addresses; port k at [k*AW +: AW]
- oRdData  out  NUM_RD*DATA_W  packed read data, registered
- oRdPending  out  NUM_RD  registered; addressed register was pending at the sample edge
- iWrEn  in  1  write enable
- iWrAddr  in  AW  write address
- iWrData  in  DATA_W  write data
- iLockEn  in  1  mark iLockAddr pending (load issued)
- iLockAddr  in  AW  register to lock
- oReady  out  1  high once the clear sweep has finished

## Operation
- States: INIT, RUN. reset forces INIT, sweep counter = 0, all pending bits = 0, oRdData = 0, oRdPending = 0, oReady = 0.
- INIT: one register per cycle is written to 0, counter 0..DEPTH-1; after the DEPTH-1 write, next state RUN, oReady = 1. Writes, locks and reads are ignored. oRdData and oRdPending hold 0.
- RUN, read: when iRdEn[k] is high, the edge loads oRdData[k] with mem[iRdAddr[k]] and oRdPending[k] with pending[iRdAddr[k]]. When iRdEn[k] is low, port k holds its previous value.
- Address 0: always reads 0 with pending 0. Writes and locks to address 0 are dropped.
- RUN, write: when iWrEn is high, the edge writes mem[iWrAddr] = iWrData and clears pending[iWrAddr].
- Lock: when iLockEn is high, the edge sets pending[iLockAddr].
- Lock and write to the same address in the same cycle: lock wins, so pending stays 1 and the data is still written.
- Read and write to the same address in the same cycle: behaviour depends on RF_BYPASS_EN (see Configuration).
- reset asserted mid-RUN: returns to INIT and the full sweep restarts. Prior contents are lost.

## Timing
- Read latency: 1 cycle, address at edge N, data valid after edge N.
- Write visible to a read sampled at edge N+1 or later, in all configurations.
- Pending set by a lock at edge N is visible to reads sampled at edge N+1 or later.
- After reset deasserts, oReady rises exactly DEPTH cycles later. Example: DEPTH=32, reset low at edge 0, oReady high after edge 32.
- No combinational path from any input to any output.

## Configuration
- RF_BYPASS_EN defined: a same-cycle write to the address being read forwards iWrData into oRdData[k], and oRdPending[k] reports 0 unless a lock to the same address also occurs that cycle.
- RF_BYPASS_EN undefined: the read returns the old contents and the old pending bit. The pipeline must stall one cycle in that case.

## Structure
- Shared package holds: DATA_W, RF_REG_NUM and RF_REG_W defaults, the INIT/RUN state encoding, and a helper for the packed port slice.
- One natural sub-module, rf_scoreboard:
  - owns the DEPTH pending bits and the lock/clear priority;
  - is addressed by the NUM_RD read addresses and returns per-port pending.
- The storage array, sweep FSM and read registers stay in reg_file_mp.

## Test plan
- Reset sweep: preload mem via writes, pulse reset, wait 32 cycles. Requires oReady to rise after exactly 32 cycles and a read of r5 to return 0.
- Basic read/write: write r7=0xDEADBEEF, read r7 on ports 0 and 1 the next cycle. Requires both ports = 0xDEADBEEF one cycle later and pending 0.
- Register 0: write r0=0x1234 and lock r0, then read r0. Requires 0x00000000 and pending 0.
- Same-cycle read/write of r3: old value 0x11, new value 0x22.
  - With RF_BYPASS_EN: port returns 0x22.
  - Without RF_BYPASS_EN: port returns 0x11, then 0x22 on the next read.
- Scoreboard: lock r9, read r9 (pending 1); write r9=0x55 while relocking r9 (pending stays 1); write r9=0x66 alone, then read (pending 0, data 0x66).
- Reset mid-operation: assert reset during RUN with r4=0xAA. Requires oReady=0 for 32 cycles, r4 reads 0 afterwards, and writes issued during INIT are lost.

Source files
------------

// File: rtl/reg_file_mp_pkg.sv
// Shared constants, sweep FSM encoding and packed-port slicing helper for the
// multi-port register file.
package reg_file_mp_pkg;

   localparam int DATA_W     = 32;
   localparam int RF_REG_NUM = 32;
   localparam int RF_REG_W   = $clog2(RF_REG_NUM);

   typedef enum logic {
      ST_INIT = 1'b0,
      ST_RUN  = 1'b1
   } state_t;

   // LSB position of port `port` inside a packed bus of `width`-bit fields.
   function automatic int slice_lsb(input int port, input int width);
      return port * width;
   endfunction

endpackage

// File: rtl/reg_file_mp_if.sv
// Decode/write-back side bus of reg_file_mp: read ports, write port, lock
// request and ready status.
interface reg_file_mp_if #(
   parameter int DATA_W = reg_file_mp_pkg::DATA_W,
   parameter int AW     = reg_file_mp_pkg::RF_REG_W,
   parameter int NUM_RD = 2
);
   logic [NUM_RD-1:0]        iRdEn;
   logic [NUM_RD*AW-1:0]     iRdAddr;
   logic [NUM_RD*DATA_W-1:0] oRdData;
   logic [NUM_RD-1:0]        oRdPending;
   logic                     iWrEn;
   logic [AW-1:0]            iWrAddr;
   logic [DATA_W-1:0]        iWrData;
   logic                     iLockEn;
   logic [AW-1:0]            iLockAddr;
   logic                     oReady;

   modport master (
      output iRdEn, iRdAddr, iWrEn, iWrAddr, iWrData, iLockEn, iLockAddr,
      input  oRdData, oRdPending, oReady
   );

   modport slave (
      input  iRdEn, iRdAddr, iWrEn, iWrAddr, iWrData, iLockEn, iLockAddr,
      output oRdData, oRdPending, oReady
   );
endinterface

// File: rtl/reg_file_mp_rf_scoreboard.sv
// Per-register pending bits for load-use interlock; lock beats clear.
// RF_BYPASS_EN: a same-cycle clear of a read address is forwarded to the port.
module rf_scoreboard #(
   parameter int DEPTH  = reg_file_mp_pkg::RF_REG_NUM,
   parameter int AW     = $clog2(DEPTH),
   parameter int NUM_RD = 2
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 lock_en,
   input  logic [AW-1:0]        lock_addr,
   input  logic                 clr_en,
   input  logic [AW-1:0]        clr_addr,
   input  logic [NUM_RD*AW-1:0] rd_addr,
   output logic [NUM_RD-1:0]    rd_pending
);
   import reg_file_mp_pkg::slice_lsb;

   logic [DEPTH-1:0] pending_reg;

   // Lock is applied after clear so it wins on a same-address collision.
   always_ff @(posedge clk) begin
      if (reset) begin
         pending_reg <= '0;
      end else begin
         if (clr_en)
            pending_reg[clr_addr] <= 1'b0;
         if (lock_en)
            pending_reg[lock_addr] <= 1'b1;
         pending_reg[0] <= 1'b0;
      end
   end

   generate
      for (genvar gi = 0; gi < NUM_RD; gi++) begin : g_port
         localparam int ALSB = slice_lsb(gi, AW);
         logic [AW-1:0] addr;
         assign addr = rd_addr[ALSB +: AW];
`ifdef RF_BYPASS_EN
         logic clr_hit;
         logic lock_hit;
         assign clr_hit  = clr_en && (clr_addr == addr);
         assign lock_hit = lock_en && (lock_addr == addr);
         assign rd_pending[gi] = (addr != '0) && (clr_hit ? lock_hit : pending_reg[addr]);
`else
         assign rd_pending[gi] = (addr != '0) && pending_reg[addr];
`endif
      end
   endgenerate

endmodule

// File: rtl/reg_file_mp.sv
// Multi-port MIPS register file with post-reset clear sweep and pending scoreboard.
// RF_BYPASS_EN: forwards a same-cycle write into the read ports.
module reg_file_mp #(
   parameter int DATA_W = reg_file_mp_pkg::DATA_W,
   parameter int DEPTH  = reg_file_mp_pkg::RF_REG_NUM,
   parameter int AW     = $clog2(DEPTH),
   parameter int NUM_RD = 2
) (
   input  logic         clk,
   input  logic         reset,
   reg_file_mp_if.slave bus
);
   import reg_file_mp_pkg::state_t;
   import reg_file_mp_pkg::ST_INIT;
   import reg_file_mp_pkg::ST_RUN;
   import reg_file_mp_pkg::slice_lsb;

   state_t            state_reg;
   logic [AW-1:0]     sweep_reg;
   logic              ready_reg;
   logic [DATA_W-1:0] mem [DEPTH];
   logic [NUM_RD-1:0] pend_lookup;
   logic              run;
   logic              wr_ok;
   logic              lock_ok;

   assign run     = (state_reg == ST_RUN);
   assign wr_ok   = run && bus.iWrEn && (bus.iWrAddr != '0);
   assign lock_ok = run && bus.iLockEn && (bus.iLockAddr != '0);
   assign bus.oReady = ready_reg;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg <= ST_INIT;
         sweep_reg <= '0;
         ready_reg <= 1'b0;
      end else if (state_reg == ST_INIT) begin
         sweep_reg <= sweep_reg + 1'b1;
         if (sweep_reg == AW'(DEPTH - 1)) begin
            state_reg <= ST_RUN;
            ready_reg <= 1'b1;
         end
      end
   end

   // Storage has no reset; the sweep zeroes one entry per cycle instead.
   always_ff @(posedge clk) begin
      if (!run)
         mem[sweep_reg] <= '0;
      else if (wr_ok)
         mem[bus.iWrAddr] <= bus.iWrData;
   end

   rf_scoreboard #(
      .DEPTH  (DEPTH),
      .AW     (AW),
      .NUM_RD (NUM_RD)
   ) u_scoreboard (
      .clk        (clk),
      .reset      (reset),
      .lock_en    (lock_ok),
      .lock_addr  (bus.iLockAddr),
      .clr_en     (wr_ok),
      .clr_addr   (bus.iWrAddr),
      .rd_addr    (bus.iRdAddr),
      .rd_pending (pend_lookup)
   );

   generate
      for (genvar gi = 0; gi < NUM_RD; gi++) begin : g_rd
         localparam int ALSB = slice_lsb(gi, AW);
         localparam int DLSB = slice_lsb(gi, DATA_W);
         logic [AW-1:0]     addr;
         logic [DATA_W-1:0] data_next;
         logic [DATA_W-1:0] data_reg;
         logic              pending_reg;

         assign addr = bus.iRdAddr[ALSB +: AW];

         always_comb begin
            data_next = mem[addr];
`ifdef RF_BYPASS_EN
            if (wr_ok && (bus.iWrAddr == addr))
               data_next = bus.iWrData;
`endif
            if (addr == '0)
               data_next = '0;
         end

         always_ff @(posedge clk) begin
            if (reset || !run) begin
               data_reg    <= '0;
               pending_reg <= 1'b0;
            end else if (bus.iRdEn[gi]) begin
               data_reg    <= data_next;
               pending_reg <= pend_lookup[gi];
            end
         end

         assign bus.oRdData[DLSB +: DATA_W] = data_reg;
         assign bus.oRdPending[gi]          = pending_reg;
      end
   endgenerate

endmodule

// File: tb/tb_reg_file_mp.sv
// Randomised and directed bench for reg_file_mp against an array-based
// behavioural model of register contents, pending bits and the clear sweep.
module tb_reg_file_mp;
   localparam int DW    = 32;
   localparam int DEPTH = 32;
   localparam int AW    = 5;
   localparam int NRD   = 2;

   logic clk = 1'b0;
   logic reset;

   reg_file_mp_if #(.DATA_W(DW), .AW(AW), .NUM_RD(NRD)) bus ();

   reg_file_mp #(.DATA_W(DW), .DEPTH(DEPTH), .AW(AW), .NUM_RD(NRD)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   logic [DW-1:0] m_mem  [DEPTH];
   logic          m_pend [DEPTH];
   int            init_left = DEPTH;
   logic [DW-1:0] exp_data [NRD];
   logic          exp_pend [NRD];
   logic          exp_ready;

   task automatic idle();
      bus.iRdEn = '0; bus.iRdAddr = '0;
      bus.iWrEn = 1'b0; bus.iWrAddr = '0; bus.iWrData = '0;
      bus.iLockEn = 1'b0; bus.iLockAddr = '0;
   endtask

   task automatic set_rd(input int k, input int a);
      bus.iRdEn[k] = 1'b1;
      bus.iRdAddr[k*AW +: AW] = AW'(a);
   endtask

   // Advance one edge; the model predicts what the DUT shows after that edge.
   task automatic tick();
      logic [AW-1:0] a;
      if (reset) begin
         init_left = DEPTH;
         for (int r = 0; r < DEPTH; r++) begin m_mem[r] = '0; m_pend[r] = 1'b0; end
         for (int k = 0; k < NRD; k++) begin exp_data[k] = '0; exp_pend[k] = 1'b0; end
      end else if (init_left > 0) begin
         init_left--;
         for (int k = 0; k < NRD; k++) begin exp_data[k] = '0; exp_pend[k] = 1'b0; end
      end else begin
         for (int k = 0; k < NRD; k++) begin
            if (bus.iRdEn[k]) begin
               a = bus.iRdAddr[k*AW +: AW];
               if (a == 0) begin
                  exp_data[k] = '0; exp_pend[k] = 1'b0;
               end else begin
                  exp_data[k] = m_mem[a]; exp_pend[k] = m_pend[a];
`ifdef RF_BYPASS_EN
                  if (bus.iWrEn && bus.iWrAddr == a) begin
                     exp_data[k] = bus.iWrData;
                     exp_pend[k] = bus.iLockEn && (bus.iLockAddr == a);
                  end
`endif
               end
            end
         end
         if (bus.iWrEn && bus.iWrAddr != 0) begin
            m_mem[bus.iWrAddr] = bus.iWrData; m_pend[bus.iWrAddr] = 1'b0;
         end
         if (bus.iLockEn && bus.iLockAddr != 0) m_pend[bus.iLockAddr] = 1'b1;
      end
      exp_ready = (init_left == 0);
      @(posedge clk); #1;
   endtask

   task automatic test_reset();
      reset = 1'b1; idle();
      tick(); tick();
      checks++;
      if (bus.oReady !== 1'b0 || bus.oRdData !== '0 || bus.oRdPending !== '0) begin
         errors++;
         $display("FAIL reset_state got ready=%b data=%h pend=%b exp 0/0/0", bus.oReady, bus.oRdData, bus.oRdPending);
      end
      reset = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         tick();
         checks++;
         if (bus.oReady !== exp_ready || exp_ready !== (i == DEPTH - 1)) begin
            errors++;
            $display("FAIL boot_ready cycle %0d got %b exp %b", i + 1, bus.oReady, (i == DEPTH - 1));
         end
      end
      $display("reset: boot sweep done, oReady=%b", bus.oReady);
   endtask

   task automatic test_reset_sweep();
      idle(); bus.iWrEn = 1'b1; bus.iWrAddr = 5; bus.iWrData = 32'hCAFE_0005; tick();
      idle(); set_rd(0, 5); tick();
      checks++;
      if (bus.oRdData[0 +: DW] !== 32'hCAFE_0005) begin
         errors++;
         $display("FAIL sweep_preload got %h exp %h", bus.oRdData[0 +: DW], 32'hCAFE_0005);
      end
      idle(); reset = 1'b1; tick(); reset = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         tick();
         checks++;
         if (bus.oReady !== (i == DEPTH - 1)) begin
            errors++;
            $display("FAIL sweep_ready cycle %0d got %b exp %b", i + 1, bus.oReady, (i == DEPTH - 1));
         end
      end
      set_rd(0, 5); tick();
      checks++;
      if (bus.oRdData[0 +: DW] !== '0 || bus.oRdData[0 +: DW] !== exp_data[0]) begin
         errors++;
         $display("FAIL sweep_r5 got %h exp 00000000", bus.oRdData[0 +: DW]);
      end
      $display("sweep: r5 after reset = %h", bus.oRdData[0 +: DW]);
   endtask

   task automatic test_basic();
      idle(); bus.iWrEn = 1'b1; bus.iWrAddr = 7; bus.iWrData = 32'hDEAD_BEEF; tick();
      idle(); set_rd(0, 7); set_rd(1, 7); tick();
      for (int k = 0; k < NRD; k++) begin
         checks++;
         if (bus.oRdData[k*DW +: DW] !== 32'hDEAD_BEEF || bus.oRdPending[k] !== 1'b0) begin
            errors++;
            $display("FAIL basic_port%0d got %h/%b exp deadbeef/0", k, bus.oRdData[k*DW +: DW], bus.oRdPending[k]);
         end
      end
      $display("basic: r7 ports = %h %h", bus.oRdData[0 +: DW], bus.oRdData[DW +: DW]);
   endtask

   task automatic test_reg0();
      idle(); bus.iWrEn = 1'b1; bus.iWrAddr = 0; bus.iWrData = 32'h1234;
      bus.iLockEn = 1'b1; bus.iLockAddr = 0; tick();
      idle(); set_rd(0, 0); set_rd(1, 0); tick();
      for (int k = 0; k < NRD; k++) begin
         checks++;
         if (bus.oRdData[k*DW +: DW] !== '0 || bus.oRdPending[k] !== 1'b0) begin
            errors++;
            $display("FAIL reg0_port%0d got %h/%b exp 00000000/0", k, bus.oRdData[k*DW +: DW], bus.oRdPending[k]);
         end
      end
      $display("reg0: ports = %h %h", bus.oRdData[0 +: DW], bus.oRdData[DW +: DW]);
   endtask

   task automatic test_same_cycle();
      logic [DW-1:0] want;
      idle(); bus.iWrEn = 1'b1; bus.iWrAddr = 3; bus.iWrData = 32'h11; tick();
      idle(); set_rd(0, 3); bus.iWrEn = 1'b1; bus.iWrAddr = 3; bus.iWrData = 32'h22; tick();
`ifdef RF_BYPASS_EN
      want = 32'h22;
`else
      want = 32'h11;
`endif
      checks++;
      if (bus.oRdData[0 +: DW] !== want || exp_data[0] !== want) begin
         errors++;
         $display("FAIL same_cycle_rd got %h exp %h", bus.oRdData[0 +: DW], want);
      end
      idle(); set_rd(0, 3); tick();
      checks++;
      if (bus.oRdData[0 +: DW] !== 32'h22) begin
         errors++;
         $display("FAIL same_cycle_next got %h exp 00000022", bus.oRdData[0 +: DW]);
      end
      // Write, lock and read of r3 together.
      idle(); set_rd(1, 3); bus.iWrEn = 1'b1; bus.iWrAddr = 3; bus.iWrData = 32'h33;
      bus.iLockEn = 1'b1; bus.iLockAddr = 3; tick();
      checks++;
      if (bus.oRdData[DW +: DW] !== exp_data[1] || bus.oRdPending[1] !== exp_pend[1]) begin
         errors++;
         $display("FAIL same_cycle_lock got %h/%b exp %h/%b", bus.oRdData[DW +: DW], bus.oRdPending[1], exp_data[1], exp_pend[1]);
      end
      $display("same_cycle: r3 port0=%h port1=%h pend1=%b", bus.oRdData[0 +: DW], bus.oRdData[DW +: DW], bus.oRdPending[1]);
   endtask

   task automatic test_scoreboard();
      idle(); bus.iLockEn = 1'b1; bus.iLockAddr = 9; tick();
      idle(); set_rd(0, 9); tick();
      checks++;
      if (bus.oRdPending[0] !== 1'b1) begin
         errors++;
         $display("FAIL sb_lock got %b exp 1", bus.oRdPending[0]);
      end
      idle(); bus.iWrEn = 1'b1; bus.iWrAddr = 9; bus.iWrData = 32'h55;
      bus.iLockEn = 1'b1; bus.iLockAddr = 9; tick();
      idle(); set_rd(0, 9); tick();
      checks++;
      if (bus.oRdPending[0] !== 1'b1 || bus.oRdData[0 +: DW] !== 32'h55) begin
         errors++;
         $display("FAIL sb_relock got %h/%b exp 00000055/1", bus.oRdData[0 +: DW], bus.oRdPending[0]);
      end
      idle(); bus.iWrEn = 1'b1; bus.iWrAddr = 9; bus.iWrData = 32'h66; tick();
      idle(); set_rd(0, 9); tick();
      checks++;
      if (bus.oRdPending[0] !== 1'b0 || bus.oRdData[0 +: DW] !== 32'h66) begin
         errors++;
         $display("FAIL sb_clear got %h/%b exp 00000066/0", bus.oRdData[0 +: DW], bus.oRdPending[0]);
      end
      $display("scoreboard: r9=%h pend=%b", bus.oRdData[0 +: DW], bus.oRdPending[0]);
   endtask

   task automatic test_back_to_back();
      int bad = 0;
      for (int i = 0; i < 300; i++) begin
         idle();
         for (int k = 0; k < NRD; k++) begin
            bus.iRdEn[k] = 1'($urandom_range(0, 3) != 0);
            bus.iRdAddr[k*AW +: AW] = AW'($urandom_range(0, 7));
         end
         bus.iWrEn = 1'($urandom_range(0, 1));
         bus.iWrAddr = AW'($urandom_range(0, 7));
         bus.iWrData = $urandom;
         bus.iLockEn = 1'($urandom_range(0, 2) == 0);
         bus.iLockAddr = AW'($urandom_range(0, 7));
         tick();
         for (int k = 0; k < NRD; k++) begin
            checks++;
            if (bus.oRdData[k*DW +: DW] !== exp_data[k] || bus.oRdPending[k] !== exp_pend[k]) begin
               errors++; bad++;
               $display("FAIL rand_port%0d cycle %0d got %h/%b exp %h/%b", k, i,
                        bus.oRdData[k*DW +: DW], bus.oRdPending[k], exp_data[k], exp_pend[k]);
            end
         end
      end
      $display("back_to_back: 300 random cycles, %0d mismatched ports", bad);
   endtask

   task automatic test_mid_reset();
      idle(); bus.iWrEn = 1'b1; bus.iWrAddr = 4; bus.iWrData = 32'hAA; tick();
      idle(); set_rd(0, 4); tick();
      checks++;
      if (bus.oRdData[0 +: DW] !== 32'hAA) begin
         errors++;
         $display("FAIL mid_pre got %h exp 000000aa", bus.oRdData[0 +: DW]);
      end
      idle(); reset = 1'b1; tick(); reset = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         set_rd(0, 4); set_rd(1, 4);
         bus.iWrEn = 1'b1; bus.iWrAddr = 4; bus.iWrData = 32'h77;
         bus.iLockEn = 1'b1; bus.iLockAddr = 4;
         tick();
         checks++;
         if (bus.oReady !== exp_ready || bus.oRdData !== '0 || bus.oRdPending !== '0) begin
            errors++;
            $display("FAIL mid_init cycle %0d got ready=%b data=%h pend=%b exp %b/0/0",
                     i + 1, bus.oReady, bus.oRdData, bus.oRdPending, exp_ready);
         end
      end
      idle(); set_rd(0, 4); tick();
      checks++;
      if (bus.oRdData[0 +: DW] !== '0 || bus.oRdPending[0] !== 1'b0) begin
         errors++;
         $display("FAIL mid_after got %h/%b exp 00000000/0", bus.oRdData[0 +: DW], bus.oRdPending[0]);
      end
      $display("mid_reset: r4 after sweep = %h pend=%b", bus.oRdData[0 +: DW], bus.oRdPending[0]);
   endtask

   initial begin
      reset = 1'b1;
      idle();
      test_reset();
      test_reset_sweep();
      test_basic();
      test_reg0();
      test_same_cycle();
      test_scoreboard();
      test_back_to_back();
      test_mid_reset();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
